// File: rtl/dsa_pkg.sv
// Shared types and constants for the SIMD fetch path.
package dsa_pkg;

  localparam int PIX_W  = 8;
  localparam int FRAC_W = 8;
  localparam int ADDR_W = 18;

  // Position of a tap inside a lane's 2x2 neighbourhood (slot 4L + n).
  localparam logic [1:0] N00 = 2'd0;
  localparam logic [1:0] N01 = 2'd1;
  localparam logic [1:0] N10 = 2'd2;
  localparam logic [1:0] N11 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    DRAIN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/dsa_simd_fetch_unit_if.sv
// Read port between the fetch unit and the synchronous source-image memory.
interface dsa_simd_fetch_unit_if #(
  parameter int ADDR_W = 18,
  parameter int PIX_W  = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/dsa_src_coord_calc.sv
// Maps one output coordinate to its clamped source pair (c0, c1) and fraction.
module dsa_src_coord_calc #(
  parameter int FRAC_W = 8
) (
  input  logic [15:0]       coord,
  input  logic [15:0]       scale,
  input  logic [15:0]       dim,
  output logic [15:0]       c0,
  output logic [15:0]       c1,
  output logic [FRAC_W-1:0] frac
);
  // Only integer bits [FRAC_W +: 16] and the fraction are ever used,
  // so the product is formed at exactly that width.
  logic [16+FRAC_W-1:0] prod;
  logic [15:0]          ipart;
  logic [15:0]          lim;

  // Integer/fraction split followed by clamping to the last valid column/row.
  always_comb begin
    prod  = (16+FRAC_W)'(coord) * (16+FRAC_W)'(scale);
    ipart = prod[FRAC_W +: 16];
    frac  = prod[FRAC_W-1:0];
    lim   = dim - 16'd1;
    c0    = (ipart > lim) ? lim : ipart;
    c1    = (c0 >= lim) ? lim : c0 + 16'd1;
  end

endmodule

// File: rtl/dsa_simd_fetch_unit.sv
// Fetches the 2x2 bilinear neighbourhoods for one SIMD group of output pixels.
//
// state | meaning
// IDLE  | waiting for fetch_req
// CALC  | source coordinates, fractions and row offsets are registered
// ISSUE | one memory read per cycle, 4*SIMD_WIDTH reads in total
// DRAIN | last read data is captured
// DONE  | fetch_done high; held here while hold=1
module dsa_simd_fetch_unit
  import dsa_pkg::*;
#(
  parameter int SIMD_WIDTH = 4,
  parameter int PIX_W      = dsa_pkg::PIX_W,
  parameter int ADDR_W     = dsa_pkg::ADDR_W,
  parameter int FRAC_W     = dsa_pkg::FRAC_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hold,
  input  logic                          fetch_req,
  output logic                          fetch_done,
  input  logic [15:0]                   current_x,
  input  logic [15:0]                   current_y,
  input  logic [15:0]                   img_width_in,
  input  logic [15:0]                   img_height_in,
  input  logic [15:0]                   img_width_out,
  input  logic [15:0]                   scale_x,
  input  logic [15:0]                   scale_y,
  input  logic [ADDR_W-1:0]             base_addr,
  dsa_simd_fetch_unit_if.master         mem,
  output logic [4*SIMD_WIDTH*PIX_W-1:0] lane_pixels,
  output logic [SIMD_WIDTH*FRAC_W-1:0]  lane_fx,
  output logic [FRAC_W-1:0]             lane_fy,
  output logic [SIMD_WIDTH-1:0]         lane_valid,
  output logic                          busy
);

  localparam int NSLOT = 4 * SIMD_WIDTH;
  localparam int IDX_W = $clog2(NSLOT);

  fetch_state_t      state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  cap_idx;
  logic              cap_vld;

  logic [15:0]       x0_c  [SIMD_WIDTH];
  logic [15:0]       x1_c  [SIMD_WIDTH];
  logic [FRAC_W-1:0] fx_c  [SIMD_WIDTH];
  logic [SIMD_WIDTH-1:0] valid_c;
  logic [15:0]       y0_c;
  logic [15:0]       y1_c;
  logic [FRAC_W-1:0] fy_c;

  logic [15:0]       x0_q  [SIMD_WIDTH];
  logic [15:0]       x1_q  [SIMD_WIDTH];
  logic [ADDR_W-1:0] row0_q;
  logic [ADDR_W-1:0] row1_q;

  logic [1:0]        nb;
  logic [IDX_W-3:0]  lane_sel;
  logic [15:0]       col;
  logic [ADDR_W-1:0] row;

  for (genvar l = 0; l < SIMD_WIDTH; l++) begin : g_lane
    logic [15:0] lane_x;
    assign lane_x = current_x + 16'(l);

    dsa_src_coord_calc #(.FRAC_W(FRAC_W)) u_x_calc (
      .coord (lane_x),
      .scale (scale_x),
      .dim   (img_width_in),
      .c0    (x0_c[l]),
      .c1    (x1_c[l]),
      .frac  (fx_c[l])
    );

    // Widened compare so a lane past 0xFFFF is never wrongly reported valid.
    assign valid_c[l] = (17'(current_x) + 17'(l)) < 17'(img_width_out);
  end

  dsa_src_coord_calc #(.FRAC_W(FRAC_W)) u_y_calc (
    .coord (current_y),
    .scale (scale_y),
    .dim   (img_height_in),
    .c0    (y0_c),
    .c1    (y1_c),
    .frac  (fy_c)
  );

  // Control FSM; hold freezes both state and issue index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          if (fetch_req) begin
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          state <= ISSUE;
          idx   <= '0;
        end
        ISSUE: begin
          idx <= idx + 1'b1;
          if (idx == IDX_W'(NSLOT - 1)) state <= DRAIN;
        end
        DRAIN: begin
          state      <= DONE;
          fetch_done <= 1'b1;
        end
        DONE: begin
          state      <= IDLE;
          fetch_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latch per-group geometry in CALC; these stay stable until the next CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < SIMD_WIDTH; l++) begin
        x0_q[l] <= '0;
        x1_q[l] <= '0;
      end
      row0_q     <= '0;
      row1_q     <= '0;
      lane_fx    <= '0;
      lane_fy    <= '0;
      lane_valid <= '0;
    end else if (state == CALC) begin
      for (int l = 0; l < SIMD_WIDTH; l++) begin
        x0_q[l]                     <= x0_c[l];
        x1_q[l]                     <= x1_c[l];
        lane_fx[l*FRAC_W +: FRAC_W] <= fx_c[l];
      end
      row0_q     <= ADDR_W'(y0_c) * ADDR_W'(img_width_in);
      row1_q     <= ADDR_W'(y1_c) * ADDR_W'(img_width_in);
      lane_fy    <= fy_c;
      lane_valid <= valid_c;
    end
  end

  assign nb       = idx[1:0];
  assign lane_sel = idx[IDX_W-1:2];

  // Read address for slot idx; the strobe drops in the same cycle hold rises.
  always_comb begin
    col           = (nb == N01 || nb == N11) ? x1_q[lane_sel] : x0_q[lane_sel];
    row           = (nb == N10 || nb == N11) ? row1_q : row0_q;
    mem.mem_rd_en = (state == ISSUE) && !hold;
    mem.mem_addr  = (state == ISSUE) ? (base_addr + row + ADDR_W'(col)) : '0;
  end

  // Capture read data one cycle after each strobe, independent of hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld     <= 1'b0;
      cap_idx     <= '0;
      lane_pixels <= '0;
    end else begin
      cap_vld <= mem.mem_rd_en;
      cap_idx <= idx;
      if (cap_vld) lane_pixels[32'(cap_idx)*PIX_W +: PIX_W] <= mem.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dsa_simd_fetch_unit.sv
// Scoreboard bench for dsa_simd_fetch_unit with a synchronous memory model (mem[a] = a[7:0]).
module tb_dsa_simd_fetch_unit;
  import dsa_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hold = 1'b0;
  logic         fetch_req = 1'b0;
  logic         fetch_done;
  logic [15:0]  current_x = '0, current_y = '0;
  logic [15:0]  img_width_in = 16'd4, img_height_in = 16'd4, img_width_out = 16'd4;
  logic [15:0]  scale_x = 16'h0100, scale_y = 16'h0100;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [127:0] lane_pixels;
  logic [31:0]  lane_fx;
  logic [7:0]   lane_fy;
  logic [3:0]   lane_valid;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic done_d = 1'b0;

  typedef struct {
    logic [127:0] pix;
    logic [31:0]  fx;
    logic [7:0]   fy;
    logic [3:0]   valid;
    int           req_cyc;
    int           lat;
  } res_t;

  logic [ADDR_W-1:0] exp_addr_q[$];
  res_t              exp_res_q[$];
  res_t              mon_r;

  logic [ADDR_W-1:0] a_id1 [16];
  logic [ADDR_W-1:0] a_id2 [16];
  logic [ADDR_W-1:0] a_up  [16];
  logic [ADDR_W-1:0] a_part[16];

  dsa_simd_fetch_unit_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) mem_if ();

  dsa_simd_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (hold),
    .fetch_req     (fetch_req),
    .fetch_done    (fetch_done),
    .current_x     (current_x),
    .current_y     (current_y),
    .img_width_in  (img_width_in),
    .img_height_in (img_height_in),
    .img_width_out (img_width_out),
    .scale_x       (scale_x),
    .scale_y       (scale_y),
    .base_addr     (base_addr),
    .mem           (mem_if),
    .lane_pixels   (lane_pixels),
    .lane_fx       (lane_fx),
    .lane_fy       (lane_fy),
    .lane_valid    (lane_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous source memory: data one cycle after the strobe.
  always @(posedge clk) if (mem_if.mem_rd_en) mem_if.mem_rdata <= mem_if.mem_addr[7:0];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected reads and results as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_if.mem_rd_en) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_read: got addr %0d, required no read", mem_if.mem_addr);
        end else begin
          check("read_addr", 128'(mem_if.mem_addr), 128'(exp_addr_q.pop_front()));
        end
      end
      if (fetch_done && !done_d) begin
        if (exp_res_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got fetch_done, required none");
        end else begin
          mon_r = exp_res_q.pop_front();
          check("lane_pixels", lane_pixels, mon_r.pix);
          check("lane_fx", 128'(lane_fx), 128'(mon_r.fx));
          check("lane_fy", 128'(lane_fy), 128'(mon_r.fy));
          check("lane_valid", 128'(lane_valid), 128'(mon_r.valid));
          check("done_latency", 128'(cyc - mon_r.req_cyc), 128'(mon_r.lat));
        end
      end
    end
    done_d = fetch_done;
  end

  // Issues one request; returns #1 after the edge that samples fetch_req.
  task automatic start_fetch(input logic [15:0] cx, input logic [15:0] cy,
                             input logic [15:0] win, input logic [15:0] hin,
                             input logic [15:0] wout, input logic [15:0] sx,
                             input logic [15:0] sy, input logic [ADDR_W-1:0] base,
                             input logic [ADDR_W-1:0] a [16], input int n_reads,
                             input logic [31:0] fx, input logic [7:0] fy,
                             input logic [3:0] valid, input int lat, input bit push_res);
    res_t r;
    @(posedge clk); #1;
    current_x = cx; current_y = cy;
    img_width_in = win; img_height_in = hin; img_width_out = wout;
    scale_x = sx; scale_y = sy; base_addr = base;
    for (int i = 0; i < n_reads; i++) exp_addr_q.push_back(a[i]);
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    r.pix = '0;
    for (int i = 0; i < 16; i++) r.pix[i*8 +: 8] = a[i][7:0];
    r.fx = fx; r.fy = fy; r.valid = valid;
    r.req_cyc = cyc; r.lat = lat;
    if (push_res) exp_res_q.push_back(r);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!fetch_done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!fetch_done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no fetch_done in %0d cycles, required one", name, k);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fetch_done"}, 128'(fetch_done), 128'(0));
    check({tag, "_mem_rd_en"}, 128'(mem_if.mem_rd_en), 128'(0));
    check({tag, "_mem_addr"}, 128'(mem_if.mem_addr), 128'(0));
    check({tag, "_lane_pixels"}, lane_pixels, 128'(0));
    check({tag, "_lane_fx"}, 128'(lane_fx), 128'(0));
    check({tag, "_lane_fy"}, 128'(lane_fy), 128'(0));
    check({tag, "_lane_valid"}, 128'(lane_valid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_id1  = '{4, 5, 8, 9,  5, 6, 9, 10,  6, 7, 10, 11,  7, 7, 11, 11};
    a_id2  = '{8, 9, 12, 13,  9, 10, 13, 14,  10, 11, 14, 15,  11, 11, 15, 15};
    a_up   = '{38, 39, 42, 43,  38, 39, 42, 43,  39, 39, 43, 43,  39, 39, 43, 43};
    a_part = '{4, 5, 12, 13,  5, 6, 13, 14,  6, 7, 14, 15,  7, 7, 15, 15};

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Identity 4x4, lane 0 at (0,1)
    start_fetch(0, 1, 4, 4, 4, 16'h0100, 16'h0100, 0, a_id1, 16, 32'h0, 8'h0, 4'b1111, 18, 1'b1);
    wait_done("identity");

    // 2x upscale, base offset 32
    start_fetch(4, 3, 4, 4, 8, 16'h0080, 16'h0080, 32, a_up, 16, 32'h8000_8000, 8'd128, 4'b1111, 18, 1'b1);
    wait_done("upscale");

    // Partial group: only lanes 0 and 1 inside width 6
    start_fetch(4, 0, 8, 8, 6, 16'h0100, 16'h0100, 0, a_part, 16, 32'h0, 8'h0, 4'b0011, 18, 1'b1);
    wait_done("partial");
    check("partial_reads_left", 128'(exp_addr_q.size()), 128'(0));

    // Hold for 3 cycles starting right after the 5th read
    start_fetch(0, 1, 4, 4, 4, 16'h0100, 16'h0100, 0, a_id1, 16, 32'h0, 8'h0, 4'b1111, 21, 1'b1);
    repeat (6) @(posedge clk);
    #1 hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_rd_en", 128'(mem_if.mem_rd_en), 128'(0));
      check("hold_busy", 128'(busy), 128'(1));
      @(posedge clk);
    end
    #1 hold = 1'b0;
    wait_done("hold");

    // Spurious requests during ISSUE and during DONE
    start_fetch(0, 2, 4, 4, 4, 16'h0100, 16'h0100, 0, a_id2, 16, 32'h0, 8'h0, 4'b1111, 18, 1'b1);
    repeat (4) @(posedge clk);
    #1 fetch_req = 1'b1;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    repeat (13) @(posedge clk);
    #1 fetch_req = 1'b1;
    @(negedge clk);
    check("spurious_done_high", 128'(fetch_done), 128'(1));
    @(posedge clk);
    #1 fetch_req = 1'b0;
    @(negedge clk);
    check("spurious_busy_after", 128'(busy), 128'(0));
    check("spurious_done_after", 128'(fetch_done), 128'(0));
    repeat (6) @(posedge clk);
    check("spurious_reads_left", 128'(exp_addr_q.size()), 128'(0));
    check("spurious_results_left", 128'(exp_res_q.size()), 128'(0));

    // Reset after the 6th read of a fetch
    start_fetch(0, 1, 4, 4, 4, 16'h0100, 16'h0100, 0, a_id1, 6, 32'h0, 8'h0, 4'b1111, 18, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midreset_reads_left", 128'(exp_addr_q.size()), 128'(0));
    repeat (25) @(posedge clk);
    check("midreset_no_done", 128'(done_d), 128'(0));

    // Normal fetch after the aborted one
    start_fetch(0, 1, 4, 4, 4, 16'h0100, 16'h0100, 0, a_id1, 16, 32'h0, 8'h0, 4'b1111, 18, 1'b1);
    wait_done("after_reset");
    check("final_reads_left", 128'(exp_addr_q.size()), 128'(0));
    check("final_results_left", 128'(exp_res_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
